// File: rtl/nrc_pkg.sv
// Shared constants and types for the parametrised encoder counter family.
package nrc_pkg;

    localparam int unsigned NRC_WIDTH_DEFAULT = 4;
    localparam int unsigned NRC_MAX_DEFAULT   = 7;
    localparam int unsigned NRC_THR_DEFAULT   = 4;

    typedef enum logic {
        NRC_SATURATE = 1'b0,
        NRC_WRAP     = 1'b1
    } nrc_mode_t;

endpackage

// File: rtl/nrc_counter_param.sv
// Enabled-cycle counter with runtime terminal/threshold, tc pulse and pgt flag.
// Define NRC_DOWN_EN to add the dir input for max->0 down counting.
module nrc_counter_param
    import nrc_pkg::*;
#(
    parameter int unsigned WIDTH       = NRC_WIDTH_DEFAULT,
    parameter int unsigned MAX_DEFAULT = NRC_MAX_DEFAULT,
    parameter int unsigned THR_DEFAULT = NRC_THR_DEFAULT
) (
    input  logic             clk,
    input  logic             clear,
    input  logic             restart,
    input  logic             en,
    input  logic             wrap,
`ifdef NRC_DOWN_EN
    input  logic             dir,
`endif
    input  logic             cfg_load,
    input  logic [WIDTH-1:0] cfg_max,
    input  logic [WIDTH-1:0] cfg_thr,
    output logic [WIDTH-1:0] count,
    output logic             pgt,
    output logic             tc
);

    localparam logic [WIDTH-1:0] MAX_RST = WIDTH'(MAX_DEFAULT);
    localparam logic [WIDTH-1:0] THR_RST = WIDTH'(THR_DEFAULT);
    localparam logic [WIDTH-1:0] ONE     = WIDTH'(1);
    localparam logic             PGT_RST = (THR_RST == '0);

    logic [WIDTH-1:0] count_q, count_d;
    logic [WIDTH-1:0] max_q, max_d;
    logic [WIDTH-1:0] thr_q, thr_d;
    logic             pgt_q, pgt_d;
    logic             tc_q, tc_d;
    logic             down;
    nrc_mode_t        mode;

    assign mode = nrc_mode_t'(wrap);

`ifdef NRC_DOWN_EN
    assign down = dir;
`else
    assign down = 1'b0;
`endif

    always_comb begin
        max_d   = max_q;
        thr_d   = thr_q;
        count_d = count_q;
        tc_d    = 1'b0;
        if (cfg_load) begin
            max_d   = cfg_max;
            thr_d   = cfg_thr;
            count_d = down ? cfg_max : '0;
        end else if (restart) begin
            count_d = down ? max_q : '0;
        end else if (en) begin
            if (down) begin
                if (count_q != '0) begin
                    count_d = count_q - ONE;
                    tc_d    = (count_d == '0);
                end else if (mode == NRC_WRAP) begin
                    count_d = max_q;
                    tc_d    = (max_q == '0);
                end
            end else begin
                // A count above max (never expected) behaves as if at max.
                if (count_q < max_q) begin
                    count_d = count_q + ONE;
                    tc_d    = (count_d == max_q);
                end else if (mode == NRC_WRAP) begin
                    count_d = '0;
                    tc_d    = (max_q == '0);
                end
            end
        end
        // Compare the next count so pgt is aligned with count, not a cycle late.
        pgt_d = (count_d >= thr_d);
    end

    always_ff @(posedge clk or posedge clear) begin
        if (clear) begin
            count_q <= '0;
            max_q   <= MAX_RST;
            thr_q   <= THR_RST;
            pgt_q   <= PGT_RST;
            tc_q    <= 1'b0;
        end else begin
            count_q <= count_d;
            max_q   <= max_d;
            thr_q   <= thr_d;
            pgt_q   <= pgt_d;
            tc_q    <= tc_d;
        end
    end

    assign count = count_q;
    assign pgt   = pgt_q;
    assign tc    = tc_q;

endmodule

// File: tb/tb_nrc_counter_param.sv
// Scoreboard bench for nrc_counter_param: random and directed stimulus against
// an arithmetic reference model; a monitor pops expectations each clock.
module tb_nrc_counter_param;

    localparam int W = 4;

    logic         clk = 1'b0;
    logic         clear, restart, en, wrap, cfg_load, dir;
    logic [W-1:0] cfg_max, cfg_thr, count;
    logic         pgt, tc;

    typedef struct {
        int cnt;
        bit pgt;
        bit tc;
    } exp_t;

    exp_t exp_q[$];
    int   total = 0;
    int   bad   = 0;
    int   m_cnt, m_max, m_thr;

    always #5 clk = ~clk;

    nrc_counter_param #(.WIDTH(W), .MAX_DEFAULT(7), .THR_DEFAULT(4)) dut (
        .clk      (clk),
        .clear    (clear),
        .restart  (restart),
        .en       (en),
        .wrap     (wrap),
`ifdef NRC_DOWN_EN
        .dir      (dir),
`endif
        .cfg_load (cfg_load),
        .cfg_max  (cfg_max),
        .cfg_thr  (cfg_thr),
        .count    (count),
        .pgt      (pgt),
        .tc       (tc)
    );

    task automatic check(string name, int act, int req);
        total++;
        if (act != req) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, req, $time);
        end
    endtask

    // Reference: counter behaviour stated directly as integer arithmetic.
    task automatic model_edge(output exp_t e);
        bit t;
        t = 1'b0;
        if (cfg_load) begin
            m_max = int'(cfg_max);
            m_thr = int'(cfg_thr);
            m_cnt = dir ? m_max : 0;
        end else if (restart) begin
            m_cnt = dir ? m_max : 0;
        end else if (en) begin
            if (!dir) begin
                if (m_cnt < m_max) begin
                    m_cnt = m_cnt + 1;
                    t = (m_cnt == m_max);
                end else if (wrap) begin
                    m_cnt = 0;
                    t = (m_max == 0);
                end
            end else begin
                if (m_cnt > 0) begin
                    m_cnt = m_cnt - 1;
                    t = (m_cnt == 0);
                end else if (wrap) begin
                    m_cnt = m_max;
                    t = (m_max == 0);
                end
            end
        end
        e.cnt = m_cnt;
        e.pgt = (m_cnt >= m_thr);
        e.tc  = t;
    endtask

    task automatic step(bit ld, bit rs, bit e_n, bit wr, bit d, int mx, int th);
        exp_t e;
        @(negedge clk);
        cfg_load = ld;
        restart  = rs;
        en       = e_n;
        wrap     = wr;
        dir      = d;
        cfg_max  = W'(mx);
        cfg_thr  = W'(th);
        model_edge(e);
        exp_q.push_back(e);
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                $display("txn t=%0t count=%0d pgt=%0b tc=%0b exp=%0d/%0b/%0b",
                         $time, count, pgt, tc, e.cnt, e.pgt, e.tc);
                check("count", int'(count), e.cnt);
                check("pgt", int'(pgt), int'(e.pgt));
                check("tc", int'(tc), int'(e.tc));
            end
        end
    end

    initial begin : stim
        clear = 1'b1; restart = 1'b0; en = 1'b0; wrap = 1'b1; dir = 1'b0;
        cfg_load = 1'b0; cfg_max = '0; cfg_thr = '0;
        m_cnt = 0; m_max = 7; m_thr = 4;
        #12;
        check("rst_count", int'(count), 0);
        check("rst_pgt", int'(pgt), 0);
        check("rst_tc", int'(tc), 0);
        @(negedge clk);
        clear = 1'b0;

        // Default config wrapping, then saturating
        for (int i = 0; i < 10; i++) step(0, 0, 1, 1, 0, 0, 0);
        for (int i = 0; i < 12; i++) step(0, 0, 1, 0, 0, 0, 0);

        // Load max=3 thr=0 from count 5
        step(0, 1, 0, 1, 0, 0, 0);
        for (int i = 0; i < 5; i++) step(0, 0, 1, 1, 0, 0, 0);
        step(1, 0, 1, 1, 0, 3, 0);
        for (int i = 0; i < 5; i++) step(0, 0, 1, 1, 0, 0, 0);

        // Load beats restart/en; then async clear at count 6
        step(1, 1, 1, 1, 0, 7, 4);
        for (int i = 0; i < 6; i++) step(0, 0, 1, 1, 0, 0, 0);
        @(posedge clk);
        #3;
        clear = 1'b1;
        #1;
        check("clr_count", int'(count), 0);
        check("clr_pgt", int'(pgt), 0);
        check("clr_tc", int'(tc), 0);
        m_cnt = 0; m_max = 7; m_thr = 4;
        restart = 1'b0; en = 1'b0; cfg_load = 1'b0;
        @(negedge clk);
        clear = 1'b0;

        // thr above max, then max=0 in both modes
        step(1, 0, 0, 1, 0, 2, 5);
        for (int i = 0; i < 8; i++) step(0, 0, 1, 1, 0, 0, 0);
        step(1, 0, 0, 1, 0, 0, 2);
        for (int i = 0; i < 5; i++) step(0, 0, 1, 1, 0, 0, 0);
        for (int i = 0; i < 3; i++) step(0, 0, 1, 0, 0, 0, 0);

`ifdef NRC_DOWN_EN
        step(1, 0, 0, 1, 1, 7, 4);
        for (int i = 0; i < 10; i++) step(0, 0, 1, 1, 1, 0, 0);
`endif

        // Randomised traffic
        step(1, 0, 0, 1, 0, 7, 4);
        for (int i = 0; i < 300; i++) begin
            bit d;
            d = 1'b0;
`ifdef NRC_DOWN_EN
            d = ($urandom_range(0, 3) == 0);
`endif
            step(($urandom_range(0, 15) == 0), ($urandom_range(0, 11) == 0),
                 ($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)), d,
                 int'($urandom_range(0, 15)), int'($urandom_range(0, 15)));
        end

        for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge clk);
        #2;
        if (exp_q.size() > 0) begin
            total++;
            bad++;
            $display("FAIL drain: %0d pending expected 0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
